// File: rtl/calc_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : calc_input_capture
// Description : Input stage for the calculator. Synchronises the raw
//               active-low push-buttons and slide switches, debounces a key
//               press, and on a clean press latches the OP code and both
//               4-bit operands into stable registers with a one-cycle
//               op_valid strobe. The next press is accepted only after a
//               debounced release.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEBOUNCE_CYCLES : number of stable cycles needed to accept a press or a
//                     release (minimum 2)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
// Ports
//   CLOCK_50 in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   key_n    in   3  raw push-buttons, active-low, asynchronous
//   sw       in   8  raw switches: [7:4] operand A, [3:0] operand B
//   op       out  3  captured OP code (active-low pattern as on key_n)
//   a        out  4  captured operand A
//   b        out  4  captured operand B
//   op_valid out  1  one-cycle strobe when op/a/b are updated
//   busy     out  1  high whenever the FSM is not idle
// ============================================================================
module calc_input_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [2:0] key_n,
  input  logic [7:0] sw,
  output logic [2:0] op,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       op_valid,
  output logic       busy
);

  localparam logic [2:0]       KEYS_UP   = 3'b111;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_HELD    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]       key_meta;
  logic [2:0]       ks;
  logic [7:0]       sw_meta;
  logic [7:0]       ss;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;

  logic             cnt_clr;
  logic             cnt_inc;
  logic             cand_load;
  logic             capture;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers; everything downstream looks only at ks/ss.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= KEYS_UP;
      ks       <= KEYS_UP;
      sw_meta  <= 8'h00;
      ss       <= 8'h00;
    end else begin
      key_meta <= key_n;
      ks       <= key_meta;
      sw_meta  <= sw;
      ss       <= sw_meta;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and counter/candidate control
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cand_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ks != KEYS_UP) begin
          cand_load  = 1'b1;
          cnt_clr    = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (ks == cand) begin
          if (cnt == CNT_LAST) begin
            state_next = S_CAPTURE;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (ks == KEYS_UP) begin
          // Bounce or too-short press: abandon without output.
          state_next = S_IDLE;
        end else begin
          // Key combination changed while settling: restart on the new one.
          cand_load = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_next = S_HELD;
      end
      S_HELD: begin
        if (ks == KEYS_UP) begin
          cnt_clr    = 1'b1;
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (ks != KEYS_UP) begin
          state_next = S_HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // The capture strobe fires on the edge that enters CAPTURE, so op/a/b and
  // op_valid change together and op_valid is high for exactly the one cycle
  // the FSM spends in CAPTURE.
  // --------------------------------------------------------------------------
  always_comb begin
    capture = (state == S_SETTLE) && (ks == cand) && (cnt == CNT_LAST);
    busy    = (state != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Debounce counter (saturating) and press candidate
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      cand <= KEYS_UP;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if (cand_load) begin
        cand <= ks;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Captured operation registers; they change only on an accepted press.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      op       <= KEYS_UP;
      a        <= 4'd0;
      b        <= 4'd0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= capture;
      if (capture) begin
        op <= cand;
        a  <= ss[7:4];
        b  <= ss[3:0];
      end
    end
  end

endmodule
`default_nettype wire
